// File: rtl/v_result_tx.sv
// v_result_tx: captures 4-lane vector-adder results on fu_ack into a two-deep
// (active/pending) buffer and serialises the active set onto the network port,
// lane 0 first, one WIDTH-bit word per net_valid/net_ready handshake.
// Ports: clk/reset (sync, active-high); fu_outputs/fu_ack/config_in/dest_in from
// the FU and config memory; net_valid/net_ready/net_data/net_dest/net_last to the
// network; fu_rdy, busy, done, ovf_err status.
module v_result_tx #(
  parameter int WIDTH     = 16,
  parameter int NUM_LANES = 4,
  parameter int DEST_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  fu_outputs [NUM_LANES-1:0],
  input  logic              fu_ack,
  input  logic [1:0]        config_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              net_valid,
  input  logic              net_ready,
  output logic [WIDTH-1:0]  net_data,
  output logic [DEST_W-1:0] net_dest,
  output logic              net_last,
  output logic              fu_rdy,
  output logic              busy,
  output logic              done,
  output logic              ovf_err
);

  typedef enum logic [1:0] {
    MODE_4X16    = 2'b00,
    MODE_2X32    = 2'b01,
    MODE_1X64    = 2'b10,
    MODE_DISCARD = 2'b11
  } mode_e;

  logic              r_a_valid;
  logic [WIDTH-1:0]  r_a_lanes [NUM_LANES-1:0];
  mode_e             r_a_mode;
  logic [DEST_W-1:0] r_a_dest;
  logic [1:0]        r_a_idx;

  logic              r_p_valid;
  logic [WIDTH-1:0]  r_p_lanes [NUM_LANES-1:0];
  mode_e             r_p_mode;
  logic [DEST_W-1:0] r_p_dest;

  logic              r_done;
  logic              r_ovf;
  logic              r_fu_rdy;

  logic              w_xfer;
  logic              w_retire;
  logic              w_a_open;
  logic              w_a_from_p;
  logic              w_a_from_in;
  logic              w_p_load;
  logic              w_drop;
  logic              w_p_valid_nxt;

  always_comb begin
    net_valid = r_a_valid && (r_a_mode != MODE_DISCARD);
    net_data  = r_a_lanes[r_a_idx];
    net_dest  = r_a_dest;
    net_last  = net_valid && (r_a_idx == 2'd3);
    fu_rdy    = r_fu_rdy;
    busy      = r_a_valid | r_p_valid;
    done      = r_done;
    ovf_err   = r_ovf;
  end

  // A is "open" when empty or retiring this edge; P then shifts into A and a
  // concurrent fu_ack can still land in P, so a full buffer only drops when A holds.
  always_comb begin
    w_xfer        = net_valid & net_ready;
    w_retire      = r_a_valid & ((r_a_mode == MODE_DISCARD) | (w_xfer & (r_a_idx == 2'd3)));
    w_a_open      = ~r_a_valid | w_retire;
    w_a_from_p    = w_a_open & r_p_valid;
    w_a_from_in   = w_a_open & ~r_p_valid & fu_ack;
    w_p_load      = fu_ack & (w_a_open ? r_p_valid : ~r_p_valid);
    w_drop        = fu_ack & ~w_a_open & r_p_valid;
    w_p_valid_nxt = w_a_open ? (r_p_valid & fu_ack) : (r_p_valid | fu_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid <= 1'b0;
      r_a_mode  <= MODE_4X16;
      r_a_dest  <= '0;
      r_a_idx   <= '0;
      r_p_valid <= 1'b0;
      r_p_mode  <= MODE_4X16;
      r_p_dest  <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_fu_rdy  <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        r_a_lanes[i] <= '0;
        r_p_lanes[i] <= '0;
      end
    end else begin
      r_done    <= w_retire;
      r_p_valid <= w_p_valid_nxt;
      r_fu_rdy  <= ~w_p_valid_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end

      if (w_a_open) begin
        r_a_idx   <= '0;
        r_a_valid <= r_p_valid | fu_ack;
      end else if (w_xfer) begin
        r_a_idx <= r_a_idx + 2'd1;
      end

      if (w_a_from_p) begin
        r_a_lanes <= r_p_lanes;
        r_a_mode  <= r_p_mode;
        r_a_dest  <= r_p_dest;
      end else if (w_a_from_in) begin
        r_a_lanes <= fu_outputs;
        r_a_mode  <= mode_e'(config_in);
        r_a_dest  <= dest_in;
      end

      if (w_p_load) begin
        r_p_lanes <= fu_outputs;
        r_p_mode  <= mode_e'(config_in);
        r_p_dest  <= dest_in;
      end
    end
  end

endmodule

// File: tb/tb_v_result_tx.sv
module tb_v_result_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] fu_outputs [3:0];
  logic        fu_ack = 1'b0;
  logic [1:0]  config_in = 2'b00;
  logic [3:0]  dest_in = 4'h0;
  logic        net_valid;
  logic        net_ready = 1'b0;
  logic [15:0] net_data;
  logic [3:0]  net_dest;
  logic        net_last;
  logic        fu_rdy;
  logic        busy;
  logic        done;
  logic        ovf_err;

  int total = 0;
  int bad = 0;

  v_result_tx #(.WIDTH(16), .NUM_LANES(4), .DEST_W(4)) dut (
    .clk(clk), .reset(reset), .fu_outputs(fu_outputs), .fu_ack(fu_ack),
    .config_in(config_in), .dest_in(dest_in), .net_valid(net_valid),
    .net_ready(net_ready), .net_data(net_data), .net_dest(net_dest),
    .net_last(net_last), .fu_rdy(fu_rdy), .busy(busy), .done(done),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of accepted result sets (head = the one on
  // the wire) with a word counter; at most two sets may be held at once.
  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  mode;
    logic [3:0]  dest;
  } set_t;

  set_t q[$];
  int   widx = 0;
  bit   m_done = 0;
  bit   m_ovf = 0;
  bit   m_rst = 1;

  function automatic logic [25:0] exp_vec();
    logic        v;
    logic [15:0] dt;
    logic [3:0]  ds;
    v  = !m_rst && q.size() > 0 && q[0].mode != 2'b11;
    dt = v ? q[0].d[16*widx +: 16] : 16'h0;
    ds = v ? q[0].dest : 4'h0;
    return {v, dt, ds, v && widx == 3, !m_rst && q.size() < 2, q.size() > 0, m_done, m_ovf};
  endfunction

  function automatic logic [25:0] obs_vec();
    return {net_valid, net_valid ? net_data : 16'h0, net_valid ? net_dest : 4'h0,
            net_last, fu_rdy, busy, done, ovf_err};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Drives one cycle of inputs, advances the model across the next edge.
  task automatic step(input bit ack, input logic [63:0] d, input logic [1:0] mode,
                      input logic [3:0] dest, input bit rdy, input bit rst);
    bit   xfer;
    bit   retire;
    set_t s;
    reset     = rst;
    fu_ack    = ack;
    for (int i = 0; i < 4; i++) fu_outputs[i] = d[16*i +: 16];
    config_in = mode;
    dest_in   = dest;
    net_ready = rdy;
    if (rst) begin
      q.delete();
      widx   = 0;
      m_done = 0;
      m_ovf  = 0;
      m_rst  = 1;
    end else begin
      m_rst  = 0;
      xfer   = q.size() > 0 && q[0].mode != 2'b11 && rdy;
      retire = q.size() > 0 && (q[0].mode == 2'b11 || (xfer && widx == 3));
      if (xfer) widx++;
      if (retire) begin
        void'(q.pop_front());
        widx = 0;
      end
      m_done = retire;
      if (ack) begin
        s.d = d; s.mode = mode; s.dest = dest;
        if (q.size() < 2) q.push_back(s);
        else m_ovf = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 64'h0, 2'b00, 4'h0, 0, 1);
    step(0, 64'h0, 2'b00, 4'h0, 1, 1);
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", obs_vec(), exp_vec());
    end
    total++;
    step(0, 64'h0, 2'b00, 4'h0, 1, 0);
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    end
    total++;
    if (fu_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_fu_rdy got=%b exp=1", fu_rdy);
    end
    total++;
  endtask

  task automatic test_single();
    logic [63:0] d = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    for (int c = 0; c < 7; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL single c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      if (c == 5) begin
        if (done !== 1'b1) begin
          bad++; $display("FAIL single_done got=%b exp=1", done);
        end
        total++;
      end
      step(c == 0, d, 2'b00, 4'h5, 1, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d = rnd64();
    for (int c = 0; c < 10; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL backpressure c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      if (c >= 2 && c <= 5) begin
        if (net_valid !== 1'b1 || net_data !== d[31:16]) begin
          bad++; $display("FAIL bp_hold c%0d got=%b/%h exp=1/%h", c, net_valid, net_data, d[31:16]);
        end
        total++;
      end
      step(c == 0, d, 2'b00, 4'h9, !(c >= 2 && c <= 4), 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1 = rnd64();
    logic [63:0] d2 = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    int dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      if (done === 1'b1) dones++;
      step(c == 0 || c == 2, (c == 2) ? d2 : d1, 2'b00, (c == 2) ? 4'h2 : 4'h1, 1, 0);
    end
    if (dones != 2) begin
      bad++; $display("FAIL b2b_dones got=%0d exp=2", dones);
    end
    total++;
  endtask

  task automatic test_mode11();
    int dones = 0;
    for (int c = 0; c < 4; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL mode11 c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      if (done === 1'b1) dones++;
      step(c == 0, rnd64(), 2'b11, 4'h3, 1, 0);
    end
    if (dones != 1) begin
      bad++; $display("FAIL mode11_dones got=%0d exp=1", dones);
    end
    total++;
    for (int c = 0; c < 16; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL simul c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      step(c == 0 || c == 1 || c == 5, rnd64(), $urandom_range(0, 2), 4'(c), c >= 2, 0);
    end
    if (ovf_err !== 1'b0) begin
      bad++; $display("FAIL simul_ovf got=%b exp=0", ovf_err);
    end
    total++;
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 16; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL overflow c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      step(c <= 2, rnd64(), 2'b00, 4'(c + 7), c >= 5, 0);
    end
    if (ovf_err !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] e = rnd64();
    for (int c = 0; c < 10; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_mid c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      if (c == 4) begin
        if (net_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          bad++; $display("FAIL reset_mid_idle got=%b%b%b exp=000", net_valid, busy, done);
        end
        total++;
      end
      if (c == 5) begin
        if (net_data !== e[15:0]) begin
          bad++; $display("FAIL reset_mid_restart got=%h exp=%h", net_data, e[15:0]);
        end
        total++;
      end
      step(c == 0 || c == 4, (c == 4) ? e : rnd64(), 2'b01, 4'hC, 1, c == 3);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      total++;
      step($urandom_range(0, 2) == 0, rnd64(), 2'($urandom_range(0, 3)), 4'($urandom()),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) fu_outputs[i] = 16'h0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_mode11();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v_result_tx.md
Name: v_result_tx

Overview:
- Sits directly downstream of the tile's vector adder FU.
- Captures each 4-lane result set when the FU pulses ack.
- Buffers up to two result sets: one active, one pending.
- Serialises the active set onto the tile's CGRA network output port, one WIDTH-bit word per handshake, tagged with the destination taken from config memory.

Parameters:
WIDTH, 16, bits per lane word and per network word
NUM_LANES, 4, lanes per FU result set (fixed at 4 for this tile)
DEST_W, 4, width of the network destination tag

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fu_outputs  in  WIDTH x NUM_LANES (unpacked [3:0])  adder FU result lanes
fu_ack  in  1  one-cycle pulse; fu_outputs valid this cycle
config_in  in  2  add mode in force for this result: 00 4x16, 01 2x32, 10 1x64, 11 discard
dest_in  in  DEST_W  destination tag from config memory; sampled with fu_ack
net_valid  out  1  network word valid
net_ready  in  1  network accepts word when net_valid is high
net_data  out  WIDTH  network word
net_dest  out  DEST_W  destination tag of the current word
net_last  out  1  high on the final word of a result set
fu_rdy  out  1  pending slot free; a fu_ack this cycle is guaranteed accepted
busy  out  1  active or pending slot occupied
done  out  1  one-cycle pulse per retired result set
ovf_err  out  1  sticky; a fu_ack was dropped

Behaviour:
- Reset: synchronous and active-high, per the already-decided rule.
  - All outputs are 0 and both slots are empty; fu_rdy is 1 the cycle after reset deasserts.
  - Reset mid-transfer abandons the result set: net_valid is 0 after the edge and no done pulse is produced.
- Storage: two slots, active (A) and pending (P).
  - Each slot holds 4 lanes, mode and dest, plus a valid bit.
  - A has a 2-bit word index idx.
- Capture when fu_ack=1:
  - A empty (or A retiring this cycle, with P empty): load into A, idx=0.
  - Else if P empty (or P moving to A this cycle): load into P.
  - Else: drop the result and set ovf_err=1. ovf_err is cleared only by reset.
- Latency: fu_ack at cycle t into an empty A gives net_valid=1 at t+1 with lane 0.
- Word order: lane 0 first, lane 3 last, in every mode.
  - 2x32 and 1x64 results are sent as their 16-bit lanes, least-significant first; no arithmetic or repacking is done.
- Handshake:
  - net_data, net_dest and net_last hold stable while net_valid=1 and net_ready=0.
  - net_valid never drops without a handshake, except on reset.
  - A transfer occurs when net_valid and net_ready are both 1; idx then increments.
  - net_last=1 exactly when idx=3.
- Retire a result set on the idx=3 transfer, or on the first cycle A holds mode 11 (no words are sent).
  - done=1 on the cycle after retire.
  - A takes P in the same edge, so the next set starts with no bubble.
  - A then empties unless P was valid or a fu_ack arrived.
- Simultaneous events: retire, P valid and fu_ack in the same cycle: P moves to A, the new result goes into P, no overflow.
- Outputs:
  - fu_rdy = !P.valid.
  - busy = A.valid | P.valid.
  - net_valid = A.valid and A.mode != 11.
  - All outputs come from registers or registered state; there is no combinational path from net_ready to net_valid.

Test Plan:
- Single set, net_ready tied 1: lanes 0x0001..0x0004, dest 5, mode 00, fu_ack at t -> net_data 1,2,3,4 on cycles t+1..t+4; net_dest 5; net_last only at t+4; done at t+5.
- Backpressure: net_ready=0 for 3 cycles during word 1 -> net_data holds 0x0002, net_valid stays 1, no word skipped or duplicated.
- Back-to-back: second fu_ack (lanes 0xA..0xD, dest 2) during the first transfer -> fu_rdy falls; set 2 starts the cycle after the first net_last with no idle cycle; two done pulses.
- Overflow: three fu_acks with net_ready=0 -> third set dropped, ovf_err=1 and held until reset; the first two sets are sent intact.
- Mode 11 and simultaneous events: a mode-11 result retires with no net_valid and one done pulse. A fu_ack coinciding with the last handshake while P is full produces no ovf_err.
- Reset mid-transfer after word 1 -> next cycle net_valid=0, busy=0, no done. A new fu_ack restarts from lane 0.
